sr_button_ctrl: RTL

Front-end for the set/reset flip-flop stage. It turns two raw, asynchronous push-button inputs into clean, single-cycle `S` and `R` command pulses for the flip-flop. Each input is synchronised, debounced and rising-edge detected. Simultaneous presses are arbitrated so the flip-flop never sees the invalid `S=R=1` combination.

---
 rtl/sr_button_ctrl_if.sv | 30 +++
 rtl/sr_button_ctrl.sv | 90 +++++++++
 2 files changed

// File: rtl/sr_button_ctrl_if.sv
// rtl/sr_button_ctrl_if.sv - button inputs and S/R command outputs of sr_button_ctrl
interface sr_button_ctrl_if;
  logic set_btn;
  logic rst_btn;
  logic S;
  logic R;
  logic set_lvl;
  logic rst_lvl;
  logic conflict;

  modport master (
    output set_btn,
    output rst_btn,
    input  S,
    input  R,
    input  set_lvl,
    input  rst_lvl,
    input  conflict
  );

  modport slave (
    input  set_btn,
    input  rst_btn,
    output S,
    output R,
    output set_lvl,
    output rst_lvl,
    output conflict
  );
endinterface

// File: rtl/sr_button_ctrl.sv
// rtl/sr_button_ctrl.sv - synchronise, debounce and edge-detect two buttons into arbitrated S/R pulses
module sr_button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input logic         clk,
  input logic         reset,
  sr_button_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             set_sync1, set_sync2, set_lvl_q;
  logic [CNT_W-1:0] set_cnt;
  logic             rst_sync1, rst_sync2, rst_lvl_q;
  logic [CNT_W-1:0] rst_cnt;

  logic set_flip, rst_flip;
  logic set_press, rst_press;

  logic s_q, r_q, conflict_q;

  // A channel flips its level on the edge its counter saturates; a press is a 0->1 flip.
  always_comb begin
    set_flip  = (set_sync2 != set_lvl_q) && (set_cnt == CNT_MAX);
    rst_flip  = (rst_sync2 != rst_lvl_q) && (rst_cnt == CNT_MAX);
    set_press = set_flip && set_sync2;
    rst_press = rst_flip && rst_sync2;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      set_sync1 <= 1'b0;
      set_sync2 <= 1'b0;
      set_cnt   <= '0;
      set_lvl_q <= 1'b0;
    end else begin
      set_sync1 <= bus.set_btn;
      set_sync2 <= set_sync1;
      if (set_sync2 == set_lvl_q) begin
        set_cnt <= '0;
      end else if (set_cnt == CNT_MAX) begin
        set_lvl_q <= set_sync2;
        set_cnt   <= '0;
      end else begin
        set_cnt <= set_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync1 <= 1'b0;
      rst_sync2 <= 1'b0;
      rst_cnt   <= '0;
      rst_lvl_q <= 1'b0;
    end else begin
      rst_sync1 <= bus.rst_btn;
      rst_sync2 <= rst_sync1;
      if (rst_sync2 == rst_lvl_q) begin
        rst_cnt <= '0;
      end else if (rst_cnt == CNT_MAX) begin
        rst_lvl_q <= rst_sync2;
        rst_cnt   <= '0;
      end else begin
        rst_cnt <= rst_cnt + 1'b1;
      end
    end
  end

  // Simultaneous presses cancel both commands so the flip-flop never sees S=R=1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      s_q        <= set_press && !rst_press;
      r_q        <= rst_press && !set_press;
      conflict_q <= set_press && rst_press;
    end
  end

  assign bus.S        = s_q;
  assign bus.R        = r_q;
  assign bus.conflict = conflict_q;
  assign bus.set_lvl  = set_lvl_q;
  assign bus.rst_lvl  = rst_lvl_q;

endmodule
